mem_fill_arbiter: RTL and testbench

Parametrised successor to the two-port cache arbiter. It shares one multicycle main memory among NUM_REQ caches (index 0 = icache, 1 = dcache by convention), with round-robin fairness. It runs block fills of configurable length and single-word write-through stores. It sits between the cache miss/write ports and the main memory, and drives the global stall_n.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mem_fill_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache fill arbiter: FSM state encoding,
// memory word geometry and an elaboration-time log2 helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    TAG   = 2'd3
  } arb_state_t;

  localparam int unsigned WORD_BYTES = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after ptr,
// searching with wrap. The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               valid
);

  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && pending[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares one multicycle main memory among NUM_REQ caches: round-robin
// arbitration, block fills of WORDS_PER_BLOCK words and single-word stores.
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_miss,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         fill_data,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [NUM_REQ-1:0]        fill_we,
  output logic [NUM_REQ-1:0]        tag_we,
  output logic [NUM_REQ-1:0]        wr_ack,
  output logic                      stall_n,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_en,
  output logic                      mem_wr,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_valid
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int unsigned WB_W  = clog2(WORD_BYTES);
  localparam int unsigned IDX_W = clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + WB_W;
  localparam logic [CNT_W-1:0] WORDS = CNT_W'(WORDS_PER_BLOCK);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   iss;
  logic [CNT_W-1:0]   rcv;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               any_pend;
  logic               rx_ok;

  // Word i of the block holding a; the block field is replaced, so no carry
  // can leave the block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [CNT_W-1:0]  i);
    logic [ADDR_W-1:0] r;
    r = a;
    r[OFF_W-1:WB_W] = i[IDX_W-1:0];
    r[WB_W-1:0] = '0;
    return r;
  endfunction

  assign pending = req_miss | req_wr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .pending   (pending),
    .ptr       (rr_ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .valid     (any_pend)
  );

  assign rx_ok = (state == FILL) && mem_valid && (rcv < WORDS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      iss     <= '0;
      rcv     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_pend) begin
            gnt_q   <= win_oh;
            addr_q  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            iss     <= '0;
            rcv     <= '0;
            rr_ptr  <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            state   <= req_wr[win_idx] ? WRITE : FILL;
          end
        end
        WRITE: begin
          gnt_q <= '0;
          state <= IDLE;
        end
        FILL: begin
          if (iss < WORDS) iss <= iss + 1'b1;
          if (rx_ok) begin
            rcv <= rcv + 1'b1;
            if (rcv == WORDS - 1'b1) state <= TAG;
          end
        end
        TAG: begin
          gnt_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign stall_n = (state == IDLE) && !(|pending);

  always_comb begin
    fill_data = '0;
    fill_addr = '0;
    fill_we   = '0;
    tag_we    = '0;
    wr_ack    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    unique case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        wr_ack    = gnt_q;
      end
      FILL: begin
        if (iss < WORDS) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(addr_q, iss);
        end
        if (rx_ok) begin
          fill_we   = gnt_q;
          fill_data = mem_rdata;
          fill_addr = word_addr(addr_q, rcv);
        end
      end
      TAG: begin
        tag_we    = gnt_q;
        fill_addr = word_addr(addr_q, '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed scoreboard bench: two arbiters (2 req / 8-word blocks, 4 req /
// 4-word blocks) each against a fixed-latency memory model.
module tb_mem_fill_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NA = 2;
  localparam int WA = 8;
  localparam int LA = 4;
  localparam int NB = 4;
  localparam int WB = 4;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0]    a_miss = '0, a_wr = '0;
  logic [NA*AW-1:0] a_addr = '0;
  logic [NA*DW-1:0] a_wdata = '0;
  logic [NA-1:0]    a_gnt, a_fill_we, a_tag_we, a_wr_ack;
  logic [DW-1:0]    a_fill_data, a_mem_wdata;
  logic [AW-1:0]    a_fill_addr, a_mem_addr;
  logic             a_stall_n, a_mem_en, a_mem_wr;
  logic [DW-1:0]    a_mem_rdata = '0;
  logic             a_mem_valid = 1'b0;

  logic [NB-1:0]    b_miss = '0, b_wr = '0;
  logic [NB*AW-1:0] b_addr = '0;
  logic [NB*DW-1:0] b_wdata = '0;
  logic [NB-1:0]    b_gnt, b_fill_we, b_tag_we, b_wr_ack;
  logic [DW-1:0]    b_fill_data, b_mem_wdata;
  logic [AW-1:0]    b_fill_addr, b_mem_addr;
  logic             b_stall_n, b_mem_en, b_mem_wr;
  logic [DW-1:0]    b_mem_rdata = '0;
  logic             b_mem_valid = 1'b0;

  mem_fill_arbiter #(
    .NUM_REQ(NA), .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req_miss(a_miss), .req_addr(a_addr),
    .req_wr(a_wr), .req_wdata(a_wdata), .gnt(a_gnt), .fill_data(a_fill_data),
    .fill_addr(a_fill_addr), .fill_we(a_fill_we), .tag_we(a_tag_we),
    .wr_ack(a_wr_ack), .stall_n(a_stall_n), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_en(a_mem_en), .mem_wr(a_mem_wr),
    .mem_rdata(a_mem_rdata), .mem_valid(a_mem_valid)
  );

  mem_fill_arbiter #(
    .NUM_REQ(NB), .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_miss(b_miss), .req_addr(b_addr),
    .req_wr(b_wr), .req_wdata(b_wdata), .gnt(b_gnt), .fill_data(b_fill_data),
    .fill_addr(b_fill_addr), .fill_we(b_fill_we), .tag_we(b_tag_we),
    .wr_ack(b_wr_ack), .stall_n(b_stall_n), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_en(b_mem_en), .mem_wr(b_mem_wr),
    .mem_rdata(b_mem_rdata), .mem_valid(b_mem_valid)
  );

  typedef struct { int due; logic [AW-1:0] addr; } pend_t;
  typedef struct { logic [3:0] who; logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;

  pend_t         a_pipe[$], b_pipe[$];
  ev_t           fill_q[$], tag_q[$], wr_q[$];
  logic [AW-1:0] iss_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_first_iss = 0, a_tag_cyc = 0, a_wr_cyc = 0;
  bit a_prev_iss = 1'b0;

  bit         b_phase = 1'b0;
  logic [3:0] b_prev_gnt = '0;
  int         b_ngrant = 0, b_nfill = 0, b_ntag = 0;
  logic [3:0] b_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         b_oidx[5]  = '{0, 1, 2, 3, 0};
  logic [AW-1:0] b_base[4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};

  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor_a();
    ev_t e;
    logic [AW-1:0] ea;
    if (a_mem_en && !a_mem_wr) begin
      a_pipe.push_back('{cyc + LA, a_mem_addr});
      if (!a_prev_iss) a_first_iss = cyc;
      chk("a_issue_expected", 64'(iss_q.size() > 0), 1);
      if (iss_q.size() > 0) begin
        ea = iss_q.pop_front();
        chk("a_mem_addr", a_mem_addr, ea);
      end
    end
    a_prev_iss = a_mem_en && !a_mem_wr;
    if (a_mem_en && a_mem_wr) begin
      a_wr_cyc = cyc;
      chk("a_write_expected", 64'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("a_wr_addr", a_mem_addr, e.addr);
        chk("a_wr_data", a_mem_wdata, e.data);
        chk("a_wr_ack", a_wr_ack, e.who);
      end
    end else if (a_wr_ack != 0) begin
      chk("a_wr_ack_stray", a_wr_ack, 0);
    end
    if (a_fill_we != 0) begin
      chk("a_fill_expected", 64'(fill_q.size() > 0), 1);
      if (fill_q.size() > 0) begin
        e = fill_q.pop_front();
        chk("a_fill_we", a_fill_we, e.who);
        chk("a_fill_addr", a_fill_addr, e.addr);
        chk("a_fill_data", a_fill_data, e.data);
      end
    end
    if (a_tag_we != 0) begin
      a_tag_cyc = cyc;
      chk("a_tag_expected", 64'(tag_q.size() > 0), 1);
      if (tag_q.size() > 0) begin
        e = tag_q.pop_front();
        chk("a_tag_we", a_tag_we, e.who);
        chk("a_tag_addr", a_fill_addr, e.addr);
      end
    end
  endtask

  task automatic monitor_b(input bit stray);
    int oi;
    logic [AW-1:0] ea;
    if (b_mem_en && !b_mem_wr) b_pipe.push_back('{cyc + LB, b_mem_addr});
    if (!b_phase) return;
    if (stray) chk("b_stray_fill_we", b_fill_we, 0);
    if (b_gnt != 0 && b_prev_gnt == 0) begin
      chk("b_grant_in_range", 64'(b_ngrant < 5), 1);
      if (b_ngrant < 5) chk("b_grant_order", b_gnt, b_order[b_ngrant]);
      b_ngrant++;
      b_nfill = 0;
    end
    b_prev_gnt = b_gnt;
    oi = (b_ngrant > 0 && b_ngrant <= 5) ? b_oidx[b_ngrant-1] : 0;
    if (b_fill_we != 0 && b_ngrant > 0 && b_ngrant <= 5) begin
      ea = b_base[oi] + 16'(2 * b_nfill);
      chk("b_fill_we", b_fill_we, b_order[b_ngrant-1]);
      chk("b_fill_addr", b_fill_addr, ea);
      chk("b_fill_data", b_fill_data, memword(ea));
      b_nfill++;
    end
    if (b_tag_we != 0 && b_ngrant > 0 && b_ngrant <= 5) begin
      chk("b_tag_we", b_tag_we, b_order[b_ngrant-1]);
      chk("b_tag_addr", b_fill_addr, b_base[oi]);
      chk("b_fill_count", b_nfill, WB);
      b_ntag++;
      if (b_ntag == 5) b_miss = '0;
    end
  endtask

  // One clock: memory returns for this cycle, settle, check, then the cache model reacts.
  task automatic tick();
    pend_t p;
    bit b_stray;
    @(posedge clk);
    #1;
    cyc++;
    a_mem_valid = 1'b0;
    a_mem_rdata = '0;
    if (a_pipe.size() > 0 && a_pipe[0].due == cyc) begin
      p = a_pipe.pop_front();
      a_mem_valid = 1'b1;
      a_mem_rdata = memword(p.addr);
    end
    b_mem_valid = 1'b0;
    b_mem_rdata = '0;
    b_stray = 1'b0;
    if (b_pipe.size() > 0 && b_pipe[0].due == cyc) begin
      p = b_pipe.pop_front();
      b_mem_valid = 1'b1;
      b_mem_rdata = memword(p.addr);
    end else if (b_phase && b_gnt == 0) begin
      b_stray = 1'b1;
      b_mem_valid = 1'b1;
      b_mem_rdata = 16'hDEAD;
    end
    #1;
    monitor_a();
    monitor_b(b_stray);
    for (int i = 0; i < NA; i++) begin
      if (a_tag_we[i]) a_miss[i] = 1'b0;
      if (a_wr_ack[i]) a_wr[i] = 1'b0;
    end
  endtask

  task automatic push_block_a(input logic [3:0] who, input logic [AW-1:0] addr);
    logic [AW-1:0] base, wa;
    base = addr & ~16'(WA * 2 - 1);
    for (int k = 0; k < WA; k++) begin
      wa = base + 16'(2 * k);
      iss_q.push_back(wa);
      fill_q.push_back('{who, wa, memword(wa)});
    end
    tag_q.push_back('{who, base, '0});
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = 0;
    while ((fill_q.size() + tag_q.size() + iss_q.size() + wr_q.size()) != 0 && n < 300) begin
      tick();
      n++;
      chk({tag, "_stall_busy"}, a_stall_n, 0);
    end
    chk({tag, "_drained"}, fill_q.size() + tag_q.size() + iss_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    int nv;
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_stall_n", a_stall_n, 1);
    chk("rst_a_mem_en", a_mem_en, 0);
    chk("rst_a_strobes", {a_fill_we, a_tag_we, a_wr_ack}, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_b_stall_n", b_stall_n, 1);
    rst_n = 1'b1;
    tick();

    // Single icache miss
    push_block_a(4'b01, 16'h1236);
    a_addr[0*AW +: AW] = 16'h1236;
    a_miss[0] = 1'b1;
    drain_a("miss0");
    chk("miss0_fill_len", a_tag_cyc - a_first_iss, WA + LA);
    tick();
    chk("miss0_idle_gnt", a_gnt, 0);
    chk("miss0_idle_stall", a_stall_n, 1);

    // dcache write-through
    wr_q.push_back('{4'b10, 16'h0040, 16'hBEEF});
    a_addr[1*AW +: AW] = 16'h0040;
    a_wdata[1*DW +: DW] = 16'hBEEF;
    a_wr[1] = 1'b1;
    drain_a("wr1");
    tick();
    chk("wr1_stall_after1", a_stall_n, 1);
    tick();
    chk("wr1_stall_after2", a_stall_n, 1);
    chk("wr1_mem_en_idle", a_mem_en, 0);

    // Simultaneous misses from reset, then requester 0 re-misses while 1 waits
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_block_a(4'b01, 16'h2004);
    push_block_a(4'b10, 16'h301A);
    push_block_a(4'b01, 16'h4008);
    a_addr[0*AW +: AW] = 16'h2004;
    a_addr[1*AW +: AW] = 16'h301A;
    a_miss = 2'b11;
    nv = 0;
    while (tag_q.size() == 3 && nv < 100) begin
      tick();
      nv++;
    end
    chk("both_first_tag_seen", tag_q.size(), 2);
    a_addr[0*AW +: AW] = 16'h4008;
    a_miss[0] = 1'b1;
    drain_a("both");

    // Write and miss together from dcache
    tick();
    wr_q.push_back('{4'b10, 16'h0100, 16'h1234});
    push_block_a(4'b10, 16'h0100);
    a_addr[1*AW +: AW] = 16'h0100;
    a_wdata[1*DW +: DW] = 16'h1234;
    a_wr[1] = 1'b1;
    a_miss[1] = 1'b1;
    drain_a("wrmiss");
    chk("wrmiss_write_to_fill", a_first_iss - a_wr_cyc, 2);

    // Reset at the 3rd memory return of a fill
    tick();
    a_addr[0*AW +: AW] = 16'h5000;
    a_miss[0] = 1'b1;
    for (int k = 0; k < 7; k++) iss_q.push_back(16'h5000 + 16'(2 * k));
    for (int k = 0; k < 3; k++)
      fill_q.push_back('{4'b01, 16'h5000 + 16'(2 * k), memword(16'h5000 + 16'(2 * k))});
    nv = 0;
    for (int i = 0; i < 100 && nv < 3; i++) begin
      tick();
      if (a_mem_valid) nv++;
    end
    chk("rstmid_third_valid", nv, 3);
    rst_n = 1'b0;
    a_miss = '0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rstmid_gnt", a_gnt, 0);
    chk("rstmid_mem_en", a_mem_en, 0);
    chk("rstmid_stall_n", a_stall_n, 1);
    chk("rstmid_fills_left", fill_q.size(), 0);
    chk("rstmid_issues_left", iss_q.size(), 0);

    // Four requesters continuously pending
    for (int i = 0; i < NB; i++) b_addr[i*AW +: AW] = b_base[i] + 16'h0006;
    b_phase = 1'b1;
    b_miss = '1;
    for (int i = 0; i < 300 && b_ntag < 5; i++) tick();
    chk("b_tag_total", b_ntag, 5);
    chk("b_grant_total", b_ngrant, 5);
    tick();
    tick();
    chk("b_idle_gnt", b_gnt, 0);
    chk("b_idle_stall", b_stall_n, 1);
    b_phase = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
